// File: rtl/hqm_sbetgt_arb_pkg.sv
// Shared types and helpers for the sideband target-message arbiter.
// Holds the FSM state enum, byte-counter sizing and flit parity calculation.
package hqm_sbetgt_arb_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Number of flits that make up one dword for a given payload MSB.
  function automatic int bytes_per_dw(input int pldbit);
    return 32 / (pldbit + 1);
  endfunction

  // 8-bit payloads need a 2-bit byte counter; wider ones get a 1-bit counter.
  function automatic int bcnt_width(input int pldbit);
    return (pldbit == 7) ? 2 : 1;
  endfunction

  // Even parity over payload and eom. Narrow payloads are zero-extended.
  function automatic logic parity_even(input logic [31:0] pld, input logic eom);
    return ^{pld, eom};
  endfunction

endpackage

// File: rtl/hqm_sbetgt_arb_class.sv
// One message-granular round-robin arbiter for a single sideband class (PC or NP).
// Parity checking is present only when HQM_SBETGT_ARB_PARCHK_EN is defined.
module hqm_sbetgt_arb_class
  import hqm_sbetgt_arb_pkg::*;
#(
  parameter int NUM_SRC        = 2,
  parameter int INTERNALPLDBIT = 31
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_SRC-1:0]                    src_valid,
  input  logic [NUM_SRC-1:0]                    src_eom,
  input  logic [NUM_SRC-1:0]                    src_parity,
  input  logic [NUM_SRC-1:0][INTERNALPLDBIT:0]  src_payload,
  output logic [NUM_SRC-1:0]                    src_put,
  input  logic                                  free,
  output logic                                  put,
  output logic                                  eom,
  output logic                                  parity,
  output logic [INTERNALPLDBIT:0]               payload,
  output logic                                  msgip,
  output logic [NUM_SRC-1:0]                    gnt,
  output logic                                  par_err
);

  localparam int PTR_W  = $clog2(NUM_SRC);
  localparam int BCNT_W = bcnt_width(INTERNALPLDBIT);
  localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(bytes_per_dw(INTERNALPLDBIT) - 1);

  arb_state_e         state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [BCNT_W-1:0]  bcnt;
  logic [NUM_SRC-1:0] winner;
  logic [PTR_W-1:0]   gnt_idx;
  logic               sel_valid;
  logic               found;
  int                 idx;
  logic               last_byte;
  logic               final_put;

  // NOTE: every always_comb output gets a default before the loops so no latch is inferred.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 0; i < NUM_SRC; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_SRC;
      if (!found && src_valid[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  // gnt is one-hot while LOCKED and zero while IDLE, so the AND-OR mux reads zero when idle.
  always_comb begin
    gnt_idx   = '0;
    sel_valid = 1'b0;
    eom       = 1'b0;
    parity    = 1'b0;
    payload   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (gnt[i]) begin
        gnt_idx   = PTR_W'(i);
        sel_valid = src_valid[i];
        eom       = src_eom[i];
        parity    = src_parity[i];
        payload   = src_payload[i];
      end
    end
  end

  assign put       = (state == ARB_LOCKED) && sel_valid && free;
  assign src_put   = gnt & {NUM_SRC{put}};
  assign last_byte = (bcnt == LAST_BYTE);
  assign final_put = put && eom && last_byte;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ARB_IDLE;
      gnt    <= '0;
      rr_ptr <= '0;
      bcnt   <= '0;
      msgip  <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (|src_valid) begin
            gnt   <= winner;
            state <= ARB_LOCKED;
          end
        end
        ARB_LOCKED: begin
          if (put) begin
            bcnt <= last_byte ? '0 : bcnt + 1'b1;
            if (final_put) begin
              state  <= ARB_IDLE;
              gnt    <= '0;
              rr_ptr <= PTR_W'((int'(gnt_idx) + 1) % NUM_SRC);
              msgip  <= 1'b0;
            end else begin
              msgip <= 1'b1;
            end
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

`ifdef HQM_SBETGT_ARB_PARCHK_EN
  // A bad flit is still forwarded; the error is only flagged the cycle after its put.
  always_ff @(posedge clk) begin
    if (rst) begin
      par_err <= 1'b0;
    end else begin
      par_err <= put && (parity != parity_even(32'(payload), eom));
    end
  end
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: rtl/hqm_sbetgt_msgarb.sv
// Shares one IOSF sideband target interface (PC and NP) between NUM_SRC sources.
// Define HQM_SBETGT_ARB_PARCHK_EN to enable flit parity checking on par_err.
module hqm_sbetgt_msgarb
  import hqm_sbetgt_arb_pkg::*;
#(
  parameter int NUM_SRC        = 2,
  parameter int INTERNALPLDBIT = 31
) (
  input  logic                                 agent_clk,
  input  logic                                 agent_rst,
  input  logic [NUM_SRC-1:0]                   src_pcvalid,
  input  logic [NUM_SRC-1:0]                   src_pceom,
  input  logic [NUM_SRC-1:0]                   src_pccmpl,
  input  logic [NUM_SRC-1:0]                   src_pcparity,
  input  logic [NUM_SRC-1:0][INTERNALPLDBIT:0] src_pcpayload,
  output logic [NUM_SRC-1:0]                   src_pcput,
  input  logic [NUM_SRC-1:0]                   src_npvalid,
  input  logic [NUM_SRC-1:0]                   src_npeom,
  input  logic [NUM_SRC-1:0]                   src_npparity,
  input  logic [NUM_SRC-1:0][INTERNALPLDBIT:0] src_nppayload,
  output logic [NUM_SRC-1:0]                   src_npput,
  input  logic                                 sbi_sbe_tmsg_pcfree,
  input  logic                                 sbi_sbe_tmsg_npfree,
  output logic                                 sbe_sbi_tmsg_pcput,
  output logic                                 sbe_sbi_tmsg_npput,
  output logic                                 sbe_sbi_tmsg_pceom,
  output logic                                 sbe_sbi_tmsg_npeom,
  output logic                                 sbe_sbi_tmsg_pcparity,
  output logic                                 sbe_sbi_tmsg_npparity,
  output logic                                 sbe_sbi_tmsg_pccmpl,
  output logic [INTERNALPLDBIT:0]              sbe_sbi_tmsg_pcpayload,
  output logic [INTERNALPLDBIT:0]              sbe_sbi_tmsg_nppayload,
  output logic                                 sbe_sbi_tmsg_pcmsgip,
  output logic                                 sbe_sbi_tmsg_npmsgip,
  output logic [NUM_SRC-1:0]                   pc_gnt,
  output logic [NUM_SRC-1:0]                   np_gnt,
  output logic                                 par_err
);

  logic pc_par_err;
  logic np_par_err;

  hqm_sbetgt_arb_class #(
    .NUM_SRC        (NUM_SRC),
    .INTERNALPLDBIT (INTERNALPLDBIT)
  ) u_pc (
    .clk         (agent_clk),
    .rst         (agent_rst),
    .src_valid   (src_pcvalid),
    .src_eom     (src_pceom),
    .src_parity  (src_pcparity),
    .src_payload (src_pcpayload),
    .src_put     (src_pcput),
    .free        (sbi_sbe_tmsg_pcfree),
    .put         (sbe_sbi_tmsg_pcput),
    .eom         (sbe_sbi_tmsg_pceom),
    .parity      (sbe_sbi_tmsg_pcparity),
    .payload     (sbe_sbi_tmsg_pcpayload),
    .msgip       (sbe_sbi_tmsg_pcmsgip),
    .gnt         (pc_gnt),
    .par_err     (pc_par_err)
  );

  hqm_sbetgt_arb_class #(
    .NUM_SRC        (NUM_SRC),
    .INTERNALPLDBIT (INTERNALPLDBIT)
  ) u_np (
    .clk         (agent_clk),
    .rst         (agent_rst),
    .src_valid   (src_npvalid),
    .src_eom     (src_npeom),
    .src_parity  (src_npparity),
    .src_payload (src_nppayload),
    .src_put     (src_npput),
    .free        (sbi_sbe_tmsg_npfree),
    .put         (sbe_sbi_tmsg_npput),
    .eom         (sbe_sbi_tmsg_npeom),
    .parity      (sbe_sbi_tmsg_npparity),
    .payload     (sbe_sbi_tmsg_nppayload),
    .msgip       (sbe_sbi_tmsg_npmsgip),
    .gnt         (np_gnt),
    .par_err     (np_par_err)
  );

  // Completion flag only exists on PC; it follows the PC owner like the other flit fields.
  assign sbe_sbi_tmsg_pccmpl = |(src_pccmpl & pc_gnt);
  assign par_err             = pc_par_err | np_par_err;

endmodule

// File: tb/tb_hqm_sbetgt_msgarb.sv
// Self-checking bench for hqm_sbetgt_msgarb: queue-based sources plus an in-order scoreboard.
// A second instance with 8-bit payloads exercises byte mode.
module tb_hqm_sbetgt_msgarb;
  localparam int N   = 2;
  localparam int PB  = 31;
  localparam int PBB = 7;

  logic agent_clk = 1'b0;
  always #5 agent_clk = ~agent_clk;
  logic agent_rst;

  logic [N-1:0]       src_pcvalid, src_pceom, src_pccmpl, src_pcparity, src_pcput;
  logic [N-1:0][PB:0] src_pcpayload;
  logic [N-1:0]       src_npvalid, src_npeom, src_npparity, src_npput;
  logic [N-1:0][PB:0] src_nppayload;
  logic               pcfree, npfree;
  logic               pcput, npput, pceom, npeom, pcpar, nppar, pccmpl, pcmsgip, npmsgip, par_err;
  logic [PB:0]        pcpld, nppld;
  logic [N-1:0]       pc_gnt, np_gnt;

  logic [N-1:0]        b_pcvalid, b_pceom, b_pcparity, b_pcput, b_npput, b_pc_gnt, b_np_gnt;
  logic [N-1:0][PBB:0] b_pcpayload;
  logic                b_put, b_npput_a, b_pceom_o, b_npeom_o, b_pcpar_o, b_nppar_o, b_cmpl_o;
  logic                b_pcmsgip, b_npmsgip, b_par_err;
  logic [PBB:0]        b_pcpld_o, b_nppld_o;

  hqm_sbetgt_msgarb #(.NUM_SRC(N), .INTERNALPLDBIT(PB)) dut (
    .agent_clk(agent_clk), .agent_rst(agent_rst),
    .src_pcvalid(src_pcvalid), .src_pceom(src_pceom), .src_pccmpl(src_pccmpl),
    .src_pcparity(src_pcparity), .src_pcpayload(src_pcpayload), .src_pcput(src_pcput),
    .src_npvalid(src_npvalid), .src_npeom(src_npeom), .src_npparity(src_npparity),
    .src_nppayload(src_nppayload), .src_npput(src_npput),
    .sbi_sbe_tmsg_pcfree(pcfree), .sbi_sbe_tmsg_npfree(npfree),
    .sbe_sbi_tmsg_pcput(pcput), .sbe_sbi_tmsg_npput(npput),
    .sbe_sbi_tmsg_pceom(pceom), .sbe_sbi_tmsg_npeom(npeom),
    .sbe_sbi_tmsg_pcparity(pcpar), .sbe_sbi_tmsg_npparity(nppar),
    .sbe_sbi_tmsg_pccmpl(pccmpl),
    .sbe_sbi_tmsg_pcpayload(pcpld), .sbe_sbi_tmsg_nppayload(nppld),
    .sbe_sbi_tmsg_pcmsgip(pcmsgip), .sbe_sbi_tmsg_npmsgip(npmsgip),
    .pc_gnt(pc_gnt), .np_gnt(np_gnt), .par_err(par_err)
  );

  hqm_sbetgt_msgarb #(.NUM_SRC(N), .INTERNALPLDBIT(PBB)) dut_b (
    .agent_clk(agent_clk), .agent_rst(agent_rst),
    .src_pcvalid(b_pcvalid), .src_pceom(b_pceom), .src_pccmpl('0),
    .src_pcparity(b_pcparity), .src_pcpayload(b_pcpayload), .src_pcput(b_pcput),
    .src_npvalid('0), .src_npeom('0), .src_npparity('0),
    .src_nppayload('0), .src_npput(b_npput),
    .sbi_sbe_tmsg_pcfree(1'b1), .sbi_sbe_tmsg_npfree(1'b1),
    .sbe_sbi_tmsg_pcput(b_put), .sbe_sbi_tmsg_npput(b_npput_a),
    .sbe_sbi_tmsg_pceom(b_pceom_o), .sbe_sbi_tmsg_npeom(b_npeom_o),
    .sbe_sbi_tmsg_pcparity(b_pcpar_o), .sbe_sbi_tmsg_npparity(b_nppar_o),
    .sbe_sbi_tmsg_pccmpl(b_cmpl_o),
    .sbe_sbi_tmsg_pcpayload(b_pcpld_o), .sbe_sbi_tmsg_nppayload(b_nppld_o),
    .sbe_sbi_tmsg_pcmsgip(b_pcmsgip), .sbe_sbi_tmsg_npmsgip(b_npmsgip),
    .pc_gnt(b_pc_gnt), .np_gnt(b_np_gnt), .par_err(b_par_err)
  );

  typedef struct {
    logic [31:0] pld;
    logic        eom;
    logic        par;
    logic        cmpl;
    int          src;
  } flit_t;

  flit_t pcq0[$], pcq1[$], npq0[$], npq1[$];
  flit_t pc_exp[$], np_exp[$];
  int    n_cmp = 0;
  int    n_err = 0;

  logic [N-1:0] o_pc_gnt, o_np_gnt, pc_put_s, np_put_s;
  logic         o_pcput, o_npput, o_pcmsgip, o_par_err;

  function automatic flit_t mk(input logic [31:0] pld, input logic eom, input logic cmpl,
                               input int src, input logic bad);
    flit_t f;
    f.pld  = pld;
    f.eom  = eom;
    f.cmpl = cmpl;
    f.src  = src;
    f.par  = (^{pld, eom}) ^ bad;
    return f;
  endfunction

  // Queue a whole message on one source and push the same flits to the scoreboard.
  task automatic send(input bit np, input int src, input int n, input logic [31:0] base,
                      input logic cmpl, input int bad_idx);
    flit_t f;
    for (int k = 0; k < n; k++) begin
      f = mk(base + 32'(k), k == n - 1, cmpl, src, k == bad_idx);
      if (!np && src == 0) pcq0.push_back(f);
      else if (!np)        pcq1.push_back(f);
      else if (src == 0)   npq0.push_back(f);
      else                 npq1.push_back(f);
      if (np) np_exp.push_back(f);
      else    pc_exp.push_back(f);
    end
  endtask

  task automatic drive_srcs();
    flit_t z, f;
    z = '{default: 0};
    f = (pcq0.size() > 0) ? pcq0[0] : z;
    src_pcvalid[0] = pcq0.size() > 0; src_pcpayload[0] = f.pld; src_pceom[0] = f.eom;
    src_pcparity[0] = f.par; src_pccmpl[0] = f.cmpl;
    f = (pcq1.size() > 0) ? pcq1[0] : z;
    src_pcvalid[1] = pcq1.size() > 0; src_pcpayload[1] = f.pld; src_pceom[1] = f.eom;
    src_pcparity[1] = f.par; src_pccmpl[1] = f.cmpl;
    f = (npq0.size() > 0) ? npq0[0] : z;
    src_npvalid[0] = npq0.size() > 0; src_nppayload[0] = f.pld; src_npeom[0] = f.eom;
    src_npparity[0] = f.par;
    f = (npq1.size() > 0) ? npq1[0] : z;
    src_npvalid[1] = npq1.size() > 0; src_nppayload[1] = f.pld; src_npeom[1] = f.eom;
    src_npparity[1] = f.par;
  endtask

  // One clock: drive, sample and score at negedge, then let sources retire accepted flits.
  task automatic cycle();
    flit_t        e;
    logic [N-1:0] eg;
    drive_srcs();
    @(negedge agent_clk);
    o_pcput = pcput; o_npput = npput; o_pc_gnt = pc_gnt; o_np_gnt = np_gnt;
    o_pcmsgip = pcmsgip; o_par_err = par_err;
    pc_put_s = src_pcput; np_put_s = src_npput;
    n_cmp++;
    if (pcput) begin
      if (pc_exp.size() == 0) begin
        n_err++;
        $display("FAIL pc_sb: unexpected put pld=%h, required no put", pcpld);
      end else begin
        e = pc_exp.pop_front();
        eg = '0; eg[e.src] = 1'b1;
        if ({pcpld, pceom, pcpar, pccmpl, src_pcput} !== {e.pld, e.eom, e.par, e.cmpl, eg}) begin
          n_err++;
          $display("FAIL pc_sb: got pld=%h eom=%b par=%b cmpl=%b srcput=%b, required pld=%h eom=%b par=%b cmpl=%b srcput=%b",
                   pcpld, pceom, pcpar, pccmpl, src_pcput, e.pld, e.eom, e.par, e.cmpl, eg);
        end
      end
    end else if (src_pcput !== '0) begin
      n_err++;
      $display("FAIL pc_srcput_idle: got %b, required 00", src_pcput);
    end
    n_cmp++;
    if (npput) begin
      if (np_exp.size() == 0) begin
        n_err++;
        $display("FAIL np_sb: unexpected put pld=%h, required no put", nppld);
      end else begin
        e = np_exp.pop_front();
        eg = '0; eg[e.src] = 1'b1;
        if ({nppld, npeom, nppar, src_npput} !== {e.pld, e.eom, e.par, eg}) begin
          n_err++;
          $display("FAIL np_sb: got pld=%h eom=%b par=%b srcput=%b, required pld=%h eom=%b par=%b srcput=%b",
                   nppld, npeom, nppar, src_npput, e.pld, e.eom, e.par, eg);
        end
      end
    end else if (src_npput !== '0) begin
      n_err++;
      $display("FAIL np_srcput_idle: got %b, required 00", src_npput);
    end
    @(posedge agent_clk);
    #1;
    if (pc_put_s[0] && pcq0.size() > 0) void'(pcq0.pop_front());
    if (pc_put_s[1] && pcq1.size() > 0) void'(pcq1.pop_front());
    if (np_put_s[0] && npq0.size() > 0) void'(npq0.pop_front());
    if (np_put_s[1] && npq1.size() > 0) void'(npq1.pop_front());
  endtask

  task automatic drain(input int max, input string name);
    int n = 0;
    while ((pcq0.size() + pcq1.size() + npq0.size() + npq1.size()) > 0 && n < max) begin
      cycle();
      n++;
    end
    repeat (2) cycle();
    n_cmp++;
    if ((pcq0.size() + pcq1.size() + npq0.size() + npq1.size() + pc_exp.size() + np_exp.size()) != 0) begin
      n_err++;
      $display("FAIL %s_drain: %0d flits outstanding after %0d cycles, required 0", name,
               pcq0.size() + pcq1.size() + npq0.size() + npq1.size() + pc_exp.size() + np_exp.size(), n);
    end
  endtask

  task automatic check_all_zero(input string name);
    n_cmp++;
    if ({pcput, npput, pc_gnt, np_gnt, pcmsgip, npmsgip, pceom, npeom, pcpar, nppar, pccmpl,
         pcpld, nppld, par_err, src_pcput, src_npput} !== '0) begin
      n_err++;
      $display("FAIL %s: put=%b/%b gnt=%b/%b msgip=%b/%b pld=%h/%h par_err=%b, required all 0",
               name, pcput, npput, pc_gnt, np_gnt, pcmsgip, npmsgip, pcpld, nppld, par_err);
    end
    n_cmp++;
    if ({b_put, b_pc_gnt, b_pcmsgip, b_pcpld_o, b_par_err} !== '0) begin
      n_err++;
      $display("FAIL %s_byte: put=%b gnt=%b msgip=%b pld=%h, required all 0",
               name, b_put, b_pc_gnt, b_pcmsgip, b_pcpld_o);
    end
  endtask

  task automatic test_reset();
    src_pcvalid = '0; src_pceom = '0; src_pccmpl = '0; src_pcparity = '0; src_pcpayload = '0;
    src_npvalid = '0; src_npeom = '0; src_npparity = '0; src_nppayload = '0;
    b_pcvalid = '0; b_pceom = '0; b_pcparity = '0; b_pcpayload = '0;
    pcfree = 1'b1; npfree = 1'b1;
    agent_rst = 1'b1;
    repeat (2) @(posedge agent_clk);
    @(negedge agent_clk);
    check_all_zero("reset");
    @(posedge agent_clk);
    #1 agent_rst = 1'b0;
  endtask

  task automatic test_single();
    logic [4:0] ep = 5'b01110;
    logic [4:0] ei = 5'b01100;
    send(0, 0, 3, 32'hA000_0000, 1'b1, -1);
    for (int c = 0; c < 5; c++) begin
      cycle();
      n_cmp++;
      if ({o_pcput, o_pcmsgip, o_pc_gnt} !== {ep[c], ei[c], (ep[c] ? 2'b01 : 2'b00)}) begin
        n_err++;
        $display("FAIL single c%0d: put=%b msgip=%b gnt=%b, required put=%b msgip=%b gnt=%b",
                 c, o_pcput, o_pcmsgip, o_pc_gnt, ep[c], ei[c], (ep[c] ? 2'b01 : 2'b00));
      end
    end
    // Round-robin pointer now favours src1, so it must win over src0.
    send(0, 1, 1, 32'hB100_0000, 1'b0, -1);
    send(0, 0, 1, 32'hB000_0000, 1'b0, -1);
    drain(20, "rr_after_single");
  endtask

  task automatic test_fairness();
    logic [1:0] eg;
    send(1, 0, 1, 32'hC000_0000, 1'b0, -1);
    send(1, 1, 1, 32'hC100_0000, 1'b0, -1);
    send(1, 0, 1, 32'hC000_0001, 1'b0, -1);
    send(1, 1, 1, 32'hC100_0001, 1'b0, -1);
    send(0, 0, 2, 32'hCC00_0000, 1'b1, -1);
    for (int c = 0; c < 8; c++) begin
      cycle();
      eg = (c % 2 == 0) ? 2'b00 : ((c % 4 == 1) ? 2'b01 : 2'b10);
      n_cmp++;
      if ({o_npput, o_np_gnt} !== {(c % 2 == 1), eg}) begin
        n_err++;
        $display("FAIL fairness c%0d: npput=%b np_gnt=%b, required npput=%b np_gnt=%b",
                 c, o_npput, o_np_gnt, (c % 2 == 1), eg);
      end
    end
    drain(10, "fairness");
  endtask

  task automatic test_backpressure();
    logic [7:0] fr = 8'b1110_0111;
    logic [7:0] ep = 8'b0110_0110;
    logic [7:0] eg = 8'b0111_1110;
    logic [7:0] ei = 8'b0111_1100;
    send(0, 0, 4, 32'hD000_0000, 1'b0, -1);
    for (int c = 0; c < 8; c++) begin
      pcfree = fr[c];
      cycle();
      n_cmp++;
      if ({o_pcput, o_pc_gnt, o_pcmsgip} !== {ep[c], (eg[c] ? 2'b01 : 2'b00), ei[c]}) begin
        n_err++;
        $display("FAIL backpressure c%0d: put=%b gnt=%b msgip=%b, required put=%b gnt=%b msgip=%b",
                 c, o_pcput, o_pc_gnt, o_pcmsgip, ep[c], (eg[c] ? 2'b01 : 2'b00), ei[c]);
      end
    end
    pcfree = 1'b1;
    drain(10, "backpressure");
  endtask

  task automatic test_mid_reset();
    send(0, 0, 4, 32'hE000_0000, 1'b0, -1);
    repeat (3) cycle();
    agent_rst = 1'b1;
    pcq0.delete(); pcq1.delete(); pc_exp.delete();
    cycle();
    agent_rst = 1'b0;
    drive_srcs();
    @(negedge agent_clk);
    check_all_zero("mid_reset");
    @(posedge agent_clk);
    #1;
    // The pointer is back at 0 after reset, so src0 goes before src1.
    send(0, 0, 1, 32'hE100_0000, 1'b0, -1);
    send(0, 1, 2, 32'hE200_0000, 1'b1, -1);
    drain(20, "post_reset");
  endtask

  task automatic test_byte_mode();
    logic [7:0] d;
    logic [5:0] ep = 6'b011110;
    logic [5:0] ei = 6'b011100;
    logic       e;
    int         bi = 0;
    for (int c = 0; c < 6; c++) begin
      d = 8'h11 * 8'(bi + 1);
      e = (bi == 1) || (bi == 3);
      b_pcvalid   = {1'b0, bi < 4};
      b_pcpayload = '0;
      b_pcpayload[0] = d;
      b_pceom     = {1'b0, e};
      b_pcparity  = {1'b0, ^{d, e}};
      @(negedge agent_clk);
      n_cmp++;
      if ({b_put, b_pcmsgip, b_pc_gnt, b_par_err} !== {ep[c], ei[c], (ep[c] ? 2'b01 : 2'b00), 1'b0}) begin
        n_err++;
        $display("FAIL byte_mode c%0d: put=%b msgip=%b gnt=%b par_err=%b, required put=%b msgip=%b gnt=%b par_err=0",
                 c, b_put, b_pcmsgip, b_pc_gnt, b_par_err, ep[c], ei[c], (ep[c] ? 2'b01 : 2'b00));
      end
      if (ep[c]) begin
        n_cmp++;
        if (b_pcpld_o !== d) begin
          n_err++;
          $display("FAIL byte_pld c%0d: got %h, required %h", c, b_pcpld_o, d);
        end
      end
      @(posedge agent_clk);
      #1;
      if (ep[c]) bi++;
    end
    b_pcvalid = '0;
  endtask

  task automatic test_parity();
`ifdef HQM_SBETGT_ARB_PARCHK_EN
    logic [4:0] epe = 5'b01000;
`else
    logic [4:0] epe = 5'b00000;
`endif
    send(0, 1, 3, 32'hF000_00F0, 1'b0, 1);
    for (int c = 0; c < 5; c++) begin
      cycle();
      n_cmp++;
      if (o_par_err !== epe[c]) begin
        n_err++;
        $display("FAIL parity c%0d: par_err=%b, required %b", c, o_par_err, epe[c]);
      end
    end
    drain(10, "parity");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_mid_reset();
    test_byte_mode();
    test_parity();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hqm_sbetgt_msgarb.md
# hqm_sbetgt_msgarb

Message-granular arbiter that shares one IOSF sideband target interface, posted/completion (PC) and non-posted (NP), between NUM_SRC upstream target-message sources. It sits between the per-port target repeaters and the agent target interface. It also keeps whole messages contiguous per class, and drives the message-in-progress indications toward the agent.

## Interface
Parameters:
- NUM_SRC, 2, number of requesting sources (2..8)
- INTERNALPLDBIT, 31, payload MSB (31, 15 or 7)

Ports:
- agent_clk  in  1  block clock
- agent_rst  in  1  synchronous, active-high reset
- src_pcvalid  in  NUM_SRC  source has a PC flit
- src_pceom  in  NUM_SRC  PC flit is end of message
- src_pccmpl  in  NUM_SRC  PC message is a completion
- src_pcparity  in  NUM_SRC  PC flit parity
- src_pcpayload  in  NUM_SRC x (INTERNALPLDBIT+1)  PC flit payload
- src_pcput  out  NUM_SRC  PC flit accepted from source
- src_np*  in/out  same set as the PC ports, minus cmpl  NP equivalents
- sbi_sbe_tmsg_pcfree / npfree  in  1  agent can accept a flit
- sbe_sbi_tmsg_pcput / npput  out  1  flit transfer to agent
- sbe_sbi_tmsg_pceom / npeom, pcparity / npparity, pccmpl  out  1  flit attributes
- sbe_sbi_tmsg_pcpayload / nppayload  out  INTERNALPLDBIT+1  flit payload
- sbe_sbi_tmsg_pcmsgip / npmsgip  out  1  message in progress
- pc_gnt / np_gnt  out  NUM_SRC  one-hot current owner (debug)
- par_err  out  1  parity error pulse (macro-dependent)

## Operation
- PC and NP use identical, independent arbiter instances, with no cross-class ordering.
- Per-class FSM:
  - IDLE: with any src valid, pick a winner by round-robin starting at rr_ptr. Register gnt to the winner (one-hot) and go to LOCKED. With no src valid, stay in IDLE.
  - LOCKED: put = valid[gnt] & free. src put[gnt] = put. Outputs mux the payload, eom, parity and cmpl of gnt. Payload muxes are driven whenever LOCKED, and are don't-care when put=0.
  - LOCKED → IDLE: on a put whose flit is eom and last byte. Then rr_ptr ← gnt index + 1, mod NUM_SRC, and gnt is cleared.
- Byte-wide payloads (INTERNALPLDBIT 15/7): eom is honoured only on the last byte of a dword. A 2-bit (or 1-bit) byte counter per class advances on each put.
- msgip: set on a put that is not the final eom byte, cleared on the final eom byte.
- A non-granted source never receives put. Its flits wait with no timeout.
- A source dropping valid mid-message leaves the FSM in LOCKED. This is legal: the message stalls until that source's valid returns.

## Timing
- Reset values: every put 0, all gnt 0, msgip 0, eom/parity/cmpl/payload 0, par_err 0, rr_ptr 0, FSMs IDLE.
- Arbitration latency: exactly 1 cycle from the first valid in IDLE to LOCKED. The first put can occur in the 2nd cycle.
- Within a message, flits move back-to-back at one per cycle while free and valid are both high.
- Put to the agent is combinational from valid/free in LOCKED; there is no added flop.
- Message turnaround: a 1-cycle IDLE bubble between consecutive messages.
- Reset asserted mid-message: the next cycle shows the reset values. The partial message is abandoned, and the sources are reset by the same signal.
- Simultaneous PC and NP puts are permitted.

## Configuration
- HQM_SBETGT_ARB_PARCHK_EN defined: on each put, the arbiter recomputes even parity over the payload and eom. A mismatch with the parity input raises par_err for one cycle, registered, in the cycle after the put. The flit is still forwarded.
- HQM_SBETGT_ARB_PARCHK_EN undefined: par_err is tied to 0 and no checker logic exists.

## Structure
- Shared package hqm_sbetgt_arb_pkg:
  - FSM state enum (ARB_IDLE, ARB_LOCKED)
  - byte-count width function
  - PARITY function
- Sub-module hqm_sbetgt_arb_class: one class arbiter (FSM, rr_ptr, byte counter, msgip, mux). It is instantiated twice, once for PC and once for NP. The cmpl bit is carried only by the PC instance.

## Test plan
- Single message: NUM_SRC=2, src0 sends a 3-flit PC message, free=1. Expect pc_gnt=01 in cycle 1, puts in cycles 2-4, pcmsgip=1 in cycles 3-4 and 0 after, rr_ptr=1.
- Fairness: src0 and src1 are both continuously valid with 1-flit NP messages. Grants alternate 01, 10, 01…, with a put every 2nd cycle.
- Backpressure: free is toggled 1,0,0,1 mid-message. Puts occur only on free=1 cycles, gnt stays fixed, and src put mirrors the agent put.
- Mid-message reset: reset is asserted after 2 of 4 flits. The next cycle has all outputs 0 and IDLE. A fresh message from src1 then completes normally.
- Byte mode: INTERNALPLDBIT=7, a 1-dword eom message. Expect 4 puts, msgip high after put 1 and cleared after put 4, gnt released after put 4.
- Parity (macro defined): a corrupted parity on flit 2 gives par_err=1 exactly one cycle after that put, and the flit is still forwarded. With the macro undefined, par_err stays 0.
